// File: rtl/prio_enc_rr.sv
// prio_enc_rr: registered N-input priority encoder with fixed-priority or
// round-robin selection and a valid/ready output handshake.
//
// Ports:
//   clk    in  1  rising-edge clock
//   rst_n  in  1  asynchronous active-low reset
//   req    in  N  request vector, any population
//   mode   in  1  0 = fixed (highest index wins), 1 = round-robin
//   ready  in  1  downstream accepts d when ready && valid at an edge
//   d      out W  granted index (holds last grant when valid=0)
//   valid  out 1  d/multi hold a captured grant
//   multi  out 1  more than one req bit was set at capture
module prio_enc_rr #(
  parameter int unsigned N = 8,
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         mode,
  input  logic         ready,
  output logic [W-1:0] d,
  output logic         valid,
  output logic         multi
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t       state, state_nxt;
  logic [W-1:0] ptr, ptr_nxt;
  logic [W-1:0] d_nxt;
  logic         valid_nxt;
  logic         multi_nxt;
  logic [W-1:0] sel_fix;
  logic [W-1:0] sel_rr;
  logic         rr_found;
  logic         capture;

  // Position ptr+i folded back into 0..N-1 (i ranges 1..N, so one fold suffices).
  function automatic logic [W-1:0] wrap_idx(input logic [W-1:0] p, input int unsigned i);
    int unsigned s;
    s = 32'(p) + i;
    if (s >= N) s = s - N;
    return W'(s);
  endfunction

  // Candidate grants for both modes; mode picks one only at capture.
  always_comb begin : select
    sel_fix  = '0;
    sel_rr   = '0;
    rr_found = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      if (req[W'(k)]) sel_fix = W'(k);
    end
    for (int unsigned i = 1; i <= N; i++) begin
      if (!rr_found && req[wrap_idx(ptr, i)]) begin
        rr_found = 1'b1;
        sel_rr   = wrap_idx(ptr, i);
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin : next_logic
    state_nxt = state;
    d_nxt     = d;
    valid_nxt = valid;
    multi_nxt = multi;
    ptr_nxt   = ptr;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        valid_nxt = 1'b0;
        if (|req) capture = 1'b1;
      end
      HOLD: begin
        if (ready) begin
          if (|req) begin
            capture = 1'b1;
          end else begin
            valid_nxt = 1'b0;
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        valid_nxt = 1'b0;
      end
    endcase
    if (capture) begin
      d_nxt     = mode ? sel_rr : sel_fix;
      ptr_nxt   = mode ? sel_rr : sel_fix;
      multi_nxt = (req & (req - N'(1))) != '0;
      valid_nxt = 1'b1;
      state_nxt = HOLD;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      d     <= '0;
      valid <= 1'b0;
      multi <= 1'b0;
      ptr   <= W'(N - 1);
    end else begin
      state <= state_nxt;
      d     <= d_nxt;
      valid <= valid_nxt;
      multi <= multi_nxt;
      ptr   <= ptr_nxt;
    end
  end

endmodule

// File: tb/tb_prio_enc_rr.sv
module tb_prio_enc_rr;

  logic       clk;
  logic       rst_n;
  logic       mode;
  logic       ready;
  logic [7:0] req8;
  logic [4:0] req5;
  logic [2:0] d8, d5;
  logic       valid8, valid5, multi8, multi5;

  int pass_cnt;
  int total_cnt;

  prio_enc_rr #(.N(8), .W(3)) dut8 (
    .clk(clk), .rst_n(rst_n), .req(req8), .mode(mode), .ready(ready),
    .d(d8), .valid(valid8), .multi(multi8)
  );

  prio_enc_rr #(.N(5), .W(3)) dut5 (
    .clk(clk), .rst_n(rst_n), .req(req5), .mode(mode), .ready(ready),
    .d(d5), .valid(valid5), .multi(multi5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and sample 1 time unit after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference grant: highest set index, or first set index after p going round modulo n.
  function automatic int ref_sel(input logic [7:0] r, input int n, input bit m, input int p);
    if (!m) begin
      for (int k = n - 1; k >= 0; k--) if (r[k]) return k;
    end else begin
      for (int i = 1; i <= n; i++) if (r[(p + i) % n]) return (p + i) % n;
    end
    return 0;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; req8 = 8'hFF; req5 = 5'h1F; mode = 1'b0; ready = 1'b0;
    #3;
    total_cnt++; if (d8 !== 3'd0) $display("FAIL reset_d: got %0d expected 0", d8); else pass_cnt++;
    total_cnt++; if (valid8 !== 1'b0) $display("FAIL reset_valid: got %0b expected 0", valid8); else pass_cnt++;
    total_cnt++; if (multi8 !== 1'b0) $display("FAIL reset_multi: got %0b expected 0", multi8); else pass_cnt++;
    total_cnt++; if (valid5 !== 1'b0) $display("FAIL reset_valid5: got %0b expected 0", valid5); else pass_cnt++;
    req8 = 8'h00; req5 = 5'h00;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      cyc();
      total_cnt++; if (valid8 !== 1'b0) $display("FAIL reset_idle_valid: got %0b expected 0", valid8); else pass_cnt++;
    end
  endtask

  task automatic test_fixed_single();
    mode = 1'b0; ready = 1'b1; req8 = 8'b1000_0000;
    cyc();
    total_cnt++; if (valid8 !== 1'b1) $display("FAIL single_valid: got %0b expected 1", valid8); else pass_cnt++;
    total_cnt++; if (d8 !== 3'd7) $display("FAIL single_d: got %0d expected 7", d8); else pass_cnt++;
    total_cnt++; if (multi8 !== 1'b0) $display("FAIL single_multi: got %0b expected 0", multi8); else pass_cnt++;
    req8 = 8'h00;
    cyc();
    total_cnt++; if (valid8 !== 1'b0) $display("FAIL single_drop_valid: got %0b expected 0", valid8); else pass_cnt++;
    total_cnt++; if (d8 !== 3'd7) $display("FAIL single_hold_d: got %0d expected 7", d8); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    mode = 1'b0; ready = 1'b0; req8 = 8'b0010_0100;
    cyc();
    total_cnt++; if (valid8 !== 1'b1) $display("FAIL bp_valid: got %0b expected 1", valid8); else pass_cnt++;
    total_cnt++; if (d8 !== 3'd5) $display("FAIL bp_d: got %0d expected 5", d8); else pass_cnt++;
    total_cnt++; if (multi8 !== 1'b1) $display("FAIL bp_multi: got %0b expected 1", multi8); else pass_cnt++;
    req8 = 8'b0000_0001;
    repeat (5) begin
      cyc();
      total_cnt++; if (d8 !== 3'd5) $display("FAIL bp_hold_d: got %0d expected 5", d8); else pass_cnt++;
      total_cnt++; if (multi8 !== 1'b1) $display("FAIL bp_hold_multi: got %0b expected 1", multi8); else pass_cnt++;
      total_cnt++; if (valid8 !== 1'b1) $display("FAIL bp_hold_valid: got %0b expected 1", valid8); else pass_cnt++;
    end
    ready = 1'b1;
    cyc();
    total_cnt++; if (d8 !== 3'd0) $display("FAIL bp_release_d: got %0d expected 0", d8); else pass_cnt++;
    total_cnt++; if (multi8 !== 1'b0) $display("FAIL bp_release_multi: got %0b expected 0", multi8); else pass_cnt++;
    req8 = 8'h00;
    cyc();
  endtask

  task automatic test_rr_fairness();
    int exp_seq[4] = '{0, 7, 0, 7};
    rst_n = 1'b0; #2; rst_n = 1'b1;
    mode = 1'b1; ready = 1'b1; req8 = 8'b1000_0001;
    for (int i = 0; i < 4; i++) begin
      cyc();
      total_cnt++; if (d8 !== 3'(exp_seq[i])) $display("FAIL rr2_d[%0d]: got %0d expected %0d", i, d8, exp_seq[i]); else pass_cnt++;
      total_cnt++; if (valid8 !== 1'b1) $display("FAIL rr2_valid[%0d]: got %0b expected 1", i, valid8); else pass_cnt++;
    end
    req8 = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      cyc();
      total_cnt++; if (d8 !== 3'(i % 8)) $display("FAIL rr8_d[%0d]: got %0d expected %0d", i, d8, i % 8); else pass_cnt++;
      total_cnt++; if (multi8 !== 1'b1) $display("FAIL rr8_multi[%0d]: got %0b expected 1", i, multi8); else pass_cnt++;
    end
    req8 = 8'h00;
    cyc();
  endtask

  task automatic test_rr_n5();
    int exp_seq[4] = '{1, 4, 1, 4};
    mode = 1'b1; ready = 1'b1; req5 = 5'b10010;
    for (int i = 0; i < 4; i++) begin
      cyc();
      total_cnt++; if (d5 !== 3'(exp_seq[i])) $display("FAIL rr5_d[%0d]: got %0d expected %0d", i, d5, exp_seq[i]); else pass_cnt++;
      total_cnt++; if (valid5 !== 1'b1) $display("FAIL rr5_valid[%0d]: got %0b expected 1", i, valid5); else pass_cnt++;
    end
    req5 = 5'h00;
    cyc();
  endtask

  task automatic test_async_reset();
    mode = 1'b0; ready = 1'b1; req8 = 8'b0000_1000;
    cyc();
    ready = 1'b0;
    cyc();
    total_cnt++; if (d8 !== 3'd3) $display("FAIL ar_pre_d: got %0d expected 3", d8); else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++; if (valid8 !== 1'b0) $display("FAIL ar_valid: got %0b expected 0", valid8); else pass_cnt++;
    total_cnt++; if (d8 !== 3'd0) $display("FAIL ar_d: got %0d expected 0", d8); else pass_cnt++;
    #2 rst_n = 1'b1;
    mode = 1'b1; req8 = 8'b0000_1001; ready = 1'b1;
    cyc();
    total_cnt++; if (d8 !== 3'd0) $display("FAIL ar_first_rr_d: got %0d expected 0", d8); else pass_cnt++;
    total_cnt++; if (valid8 !== 1'b1) $display("FAIL ar_first_valid: got %0b expected 1", valid8); else pass_cnt++;
    req8 = 8'h00;
    cyc();
  endtask

  task automatic test_random();
    int mv8, md8, mm8, mp8, mv5, md5, mm5, mp5, s;
    rst_n = 1'b0; #2; rst_n = 1'b1;
    mv8 = 0; md8 = 0; mm8 = 0; mp8 = 7;
    mv5 = 0; md5 = 0; mm5 = 0; mp5 = 4;
    for (int c = 0; c < 400; c++) begin
      req8  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      req5  = ($urandom_range(0, 3) == 0) ? 5'h00 : 5'($urandom);
      mode  = 1'($urandom);
      ready = ($urandom_range(0, 9) < 7);
      // A grant is taken when nothing is held or the held one is accepted.
      if ((mv8 == 0 || ready) && req8 != 0) begin
        s = ref_sel(req8, 8, mode, mp8);
        md8 = s; mp8 = s; mm8 = ($countones(req8) > 1); mv8 = 1;
      end else if (mv8 == 1 && ready) begin
        mv8 = 0;
      end
      if ((mv5 == 0 || ready) && req5 != 0) begin
        s = ref_sel({3'b000, req5}, 5, mode, mp5);
        md5 = s; mp5 = s; mm5 = ($countones(req5) > 1); mv5 = 1;
      end else if (mv5 == 1 && ready) begin
        mv5 = 0;
      end
      cyc();
      total_cnt++; if (valid8 !== 1'(mv8)) $display("FAIL rnd_valid8 c%0d: got %0b expected %0d", c, valid8, mv8); else pass_cnt++;
      total_cnt++; if (d8 !== 3'(md8)) $display("FAIL rnd_d8 c%0d: got %0d expected %0d", c, d8, md8); else pass_cnt++;
      total_cnt++; if (multi8 !== 1'(mm8)) $display("FAIL rnd_multi8 c%0d: got %0b expected %0d", c, multi8, mm8); else pass_cnt++;
      total_cnt++; if (valid5 !== 1'(mv5)) $display("FAIL rnd_valid5 c%0d: got %0b expected %0d", c, valid5, mv5); else pass_cnt++;
      total_cnt++; if (d5 !== 3'(md5)) $display("FAIL rnd_d5 c%0d: got %0d expected %0d", c, d5, md5); else pass_cnt++;
      total_cnt++; if (multi5 !== 1'(mm5)) $display("FAIL rnd_multi5 c%0d: got %0b expected %0d", c, multi5, mm5); else pass_cnt++;
    end
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    test_reset();
    test_fixed_single();
    test_backpressure();
    test_rr_fairness();
    test_rr_n5();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
